// File: rtl/counter_pkg.sv
// Shared types and parameter-legality check for the up/down counter.
package counter_pkg;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } boundary_mode_e;

  // True when MODULUS fits WIDTH bits and the largest step stays below MODULUS.
  function automatic bit params_legal(input int unsigned width,
                                      input int unsigned modulus,
                                      input int unsigned step_w);
    longint unsigned one;
    longint unsigned full_range;
    longint unsigned max_step;
    one        = 1;
    full_range = one << width;
    max_step   = (one << step_w) - one;
    return (width >= 1) && (step_w >= 1) &&
           (longint'(modulus) >= 2) &&
           (longint'(modulus) <= full_range) &&
           (max_step < longint'(modulus));
  endfunction

endpackage

// File: rtl/counter_next_calc.sv
// Combinational next-count and boundary-event calculation for a modulo-N
// up/down counter with wrap or saturate behaviour at the range ends.
module counter_next_calc
  import counter_pkg::*;
#(
  parameter int          WIDTH   = 8,
  parameter int unsigned MODULUS = 2**WIDTH,
  parameter int          STEP_W  = 2
) (
  input  logic [WIDTH-1:0]  count,
  input  logic [STEP_W-1:0] step,
  input  logic              up,
  input  boundary_mode_e    mode,
  output logic [WIDTH-1:0]  count_next,
  output logic              boundary
);

  // One extra bit so sums and the modulus itself are representable.
  localparam logic [WIDTH:0] MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] MAX_EXT = MOD_EXT - (WIDTH+1)'(1);

  logic [WIDTH:0] cnt_ext;
  logic [WIDTH:0] step_ext;
  logic [WIDTH:0] sum_up;
  logic [WIDTH:0] diff_dn;
  logic [WIDTH:0] wrapped_up;
  logic [WIDTH:0] wrapped_dn;

  always_comb begin
    cnt_ext    = {1'b0, count};
    step_ext   = (WIDTH+1)'(step);
    sum_up     = cnt_ext + step_ext;
    diff_dn    = cnt_ext - step_ext;
    wrapped_up = sum_up - MOD_EXT;
    wrapped_dn = cnt_ext + MOD_EXT - step_ext;
    count_next = count;
    boundary   = 1'b0;

    if (up) begin
      if (sum_up >= MOD_EXT) begin
        boundary   = 1'b1;
        count_next = (mode == MODE_SAT) ? WIDTH'(MAX_EXT) : WIDTH'(wrapped_up);
      end else begin
        count_next = WIDTH'(sum_up);
      end
    end else begin
      if (cnt_ext >= step_ext) begin
        count_next = WIDTH'(diff_dn);
      end else begin
        boundary   = 1'b1;
        count_next = (mode == MODE_SAT) ? '0 : WIDTH'(wrapped_dn);
      end
    end
  end

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised modulo-N up/down counter with programmable step, synchronous
// load, wrap/saturate mode, one-cycle boundary pulse and sticky overflow flag.
module updown_counter_param
  import counter_pkg::*;
#(
  parameter int          WIDTH   = 8,
  parameter int unsigned MODULUS = 2**WIDTH,
  parameter int          STEP_W  = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              nE,
  input  logic              Up,
  input  logic [STEP_W-1:0] Step,
  input  logic              Sat,
  input  logic              Load,
  input  logic [WIDTH-1:0]  LoadVal,
  input  logic              ClrOvf,
  output logic [WIDTH-1:0]  Count,
  output logic              Wrap,
  output logic              Ovf
);

  if (!params_legal(WIDTH, MODULUS, STEP_W)) begin : g_bad_params
    $error("updown_counter_param: illegal WIDTH/MODULUS/STEP_W combination");
  end

  localparam logic [WIDTH:0] MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] MAX_EXT = MOD_EXT - (WIDTH+1)'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q,  wrap_d;
  logic             ovf_q,   ovf_d;

  logic [WIDTH-1:0] calc_next;
  logic             calc_boundary;
  logic [WIDTH-1:0] load_clamped;
  boundary_mode_e   mode;

  assign mode = Sat ? MODE_SAT : MODE_WRAP;

  counter_next_calc #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS),
    .STEP_W  (STEP_W)
  ) u_next_calc (
    .count      (count_q),
    .step       (Step),
    .up         (Up),
    .mode       (mode),
    .count_next (calc_next),
    .boundary   (calc_boundary)
  );

  // Out-of-range load values pin to the top of the count range.
  assign load_clamped = ({1'b0, LoadVal} >= MOD_EXT) ? WIDTH'(MAX_EXT) : LoadVal;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    ovf_d   = ovf_q;

    if (ClrOvf) begin
      ovf_d = 1'b0;
    end

    if (Load) begin
      count_d = load_clamped;
    end else if (!nE) begin
      count_d = calc_next;
      if (calc_boundary) begin
        wrap_d = 1'b1;
        ovf_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Count = count_q;
  assign Wrap  = wrap_q;
  assign Ovf   = ovf_q;

endmodule

// File: tb/tb_updown_counter_param.sv
// Self-checking bench: directed scenarios plus random stimulus against an
// arithmetic reference model; a second default-parameter instance checks 255->0.
module tb_updown_counter_param;

  localparam int W  = 4;
  localparam int M  = 10;
  localparam int SW = 2;

  logic          Clk = 1'b0;
  logic          Reset, nE, Up, Sat, Load, ClrOvf;
  logic [SW-1:0] Step;
  logic [W-1:0]  LoadVal;
  logic [W-1:0]  Count;
  logic          Wrap, Ovf;

  logic          d_reset, d_ne, d_up, d_sat, d_load, d_clr;
  logic [1:0]    d_step;
  logic [7:0]    d_loadval;
  logic [7:0]    d_count;
  logic          d_wrap, d_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  int m_cnt  = 0;
  bit m_wrap = 1'b0;
  bit m_ovf  = 1'b0;

  always #5 Clk = ~Clk;

  updown_counter_param #(.WIDTH(W), .MODULUS(M), .STEP_W(SW)) dut (
    .Clk(Clk), .Reset(Reset), .nE(nE), .Up(Up), .Step(Step), .Sat(Sat),
    .Load(Load), .LoadVal(LoadVal), .ClrOvf(ClrOvf),
    .Count(Count), .Wrap(Wrap), .Ovf(Ovf)
  );

  updown_counter_param dut_def (
    .Clk(Clk), .Reset(d_reset), .nE(d_ne), .Up(d_up), .Step(d_step), .Sat(d_sat),
    .Load(d_load), .LoadVal(d_loadval), .ClrOvf(d_clr),
    .Count(d_count), .Wrap(d_wrap), .Ovf(d_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model written straight from the counting rules with integer math.
  task automatic model_edge();
    int  n;
    bit  ev;
    if (Reset) begin
      m_cnt = 0; m_wrap = 0; m_ovf = 0;
    end else begin
      if (ClrOvf) m_ovf = 0;
      if (Load) begin
        m_cnt  = (int'(LoadVal) >= M) ? M - 1 : int'(LoadVal);
        m_wrap = 0;
      end else if (!nE && Step != 0) begin
        if (Up) begin
          n  = m_cnt + int'(Step);
          ev = (n >= M);
          if (ev) n = Sat ? M - 1 : n % M;
        end else begin
          n  = m_cnt - int'(Step);
          ev = (n < 0);
          if (ev) n = Sat ? 0 : n + M;
        end
        m_cnt  = n;
        m_wrap = ev;
        if (ev) m_ovf = 1;
      end else begin
        m_wrap = 0;
      end
    end
  endtask

  task automatic tick(input string tag);
    @(posedge Clk);
    model_edge();
    #1;
    chk({tag, ".count"}, 32'(Count), 32'(m_cnt));
    chk({tag, ".wrap"},  32'(Wrap),  32'(m_wrap));
    chk({tag, ".ovf"},   32'(Ovf),   32'(m_ovf));
  endtask

  initial begin
    Reset = 1; nE = 1; Up = 1; Step = 0; Sat = 0; Load = 0; LoadVal = 0; ClrOvf = 0;
    d_reset = 1; d_ne = 1; d_up = 1; d_step = 0; d_sat = 0; d_load = 0; d_loadval = 0; d_clr = 0;

    // 1: reset then count up by one across the wrap
    tick("reset");
    chk("reset.const_count", 32'(Count), 32'd0);
    chk("reset.const_ovf",   32'(Ovf),   32'd0);
    chk("def_reset.count",   32'(d_count), 32'd0);
    Reset = 0; d_reset = 0;
    nE = 0; Up = 1; Step = 1; Sat = 0;
    for (int i = 1; i <= 12; i++) begin
      tick("t1");
      chk("t1.const_count", 32'(Count), 32'(i % 10));
      chk("t1.const_wrap",  32'(Wrap),  32'(i == 10));
      chk("t1.const_ovf",   32'(Ovf),   32'(i >= 10));
    end

    // 2: wrap from 8 by step 2
    Load = 1; LoadVal = 8; tick("t2.load");
    Load = 0; Step = 2; tick("t2.wrap");
    chk("t2.const_count0", 32'(Count), 32'd0);
    chk("t2.const_wrap1",  32'(Wrap),  32'd1);
    tick("t2.next");
    chk("t2.const_count2", 32'(Count), 32'd2);
    chk("t2.const_wrap0",  32'(Wrap),  32'd0);

    // 3: saturate high, set-beats-clear, then clear alone
    Load = 1; LoadVal = 8; ClrOvf = 1; tick("t3.load");
    Load = 0; ClrOvf = 0; Sat = 1; Step = 3; tick("t3.sat");
    chk("t3.const_count9", 32'(Count), 32'd9);
    chk("t3.const_ovf1",   32'(Ovf),   32'd1);
    ClrOvf = 1; tick("t3.setwins");
    chk("t3.const_hold9",  32'(Count), 32'd9);
    chk("t3.const_ovf_set", 32'(Ovf),  32'd1);
    nE = 1; tick("t3.clear");
    chk("t3.const_ovf0",   32'(Ovf),   32'd0);
    ClrOvf = 0; nE = 0;

    // 4: down wrap and down saturate
    Load = 1; LoadVal = 1; tick("t4.load");
    Load = 0; Up = 0; Step = 3; Sat = 0; tick("t4.wrap");
    chk("t4.const_count8", 32'(Count), 32'd8);
    chk("t4.const_wrap",   32'(Wrap),  32'd1);
    Load = 1; LoadVal = 1; tick("t4.reload");
    Load = 0; Sat = 1; tick("t4.sat");
    chk("t4.const_count0", 32'(Count), 32'd0);

    // 5: disabled hold, then clamped load
    nE = 1; Step = 3;
    for (int i = 0; i < 4; i++) tick("t5.hold");
    chk("t5.const_hold", 32'(Count), 32'd0);
    Load = 1; LoadVal = 12; tick("t5.clamp");
    chk("t5.const_count9", 32'(Count), 32'd9);
    chk("t5.const_wrap0",  32'(Wrap),  32'd0);

    // 6: reset beats load
    LoadVal = 5; tick("t6.load5");
    chk("t6.ovf_before", 32'(Ovf), 32'd1);
    Reset = 1; tick("t6.reset_load");
    chk("t6.const_count0", 32'(Count), 32'd0);
    chk("t6.const_ovf0",   32'(Ovf),   32'd0);
    Reset = 0; Load = 0;

    // Random phase
    for (int i = 0; i < 400; i++) begin
      Reset   = ($urandom_range(0, 49) == 0);
      nE      = ($urandom_range(0, 3) == 0);
      Up      = 1'($urandom);
      Step    = SW'($urandom);
      Sat     = 1'($urandom);
      Load    = ($urandom_range(0, 9) == 0);
      LoadVal = W'($urandom);
      ClrOvf  = ($urandom_range(0, 7) == 0);
      tick("rand");
    end
    Reset = 0; nE = 1; Load = 0; ClrOvf = 0;

    // Default parameters: 255 + 1 wraps to 0
    d_load = 1; d_loadval = 8'd255; tick("def.load");
    chk("def.load255", 32'(d_count), 32'd255);
    d_load = 0; d_ne = 0; d_up = 1; d_step = 1; d_sat = 0; tick("def.wrap");
    chk("def.count0", 32'(d_count), 32'd0);
    chk("def.wrap1",  32'(d_wrap),  32'd1);
    chk("def.ovf1",   32'(d_ovf),   32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
